// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port-owner
// encoding and the fixed access size used by the debug port.
package Dmem_Arb_PKG;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } arb_owner_t;

  // Debug accesses are always full 32-bit words.
  localparam logic [2:0] DBG_FUNCT3 = 3'b010;

endpackage

// File: rtl/dmem_arb_age_ctr.sv
// Saturating ageing counter: counts the cycles a pending debug request has
// lost arbitration to the core. Stops at MAX_WAIT and never wraps.
module dmem_arb_age_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] age;

  // Clear wins over increment; increment holds once the ceiling is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age <= '0;
    end else if (clear) begin
      age <= '0;
    end else if (inc && (age != AGE_MAX)) begin
      age <= age + AGE_W'(1);
    end
  end

  assign at_max = (age == AGE_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM stage (core) and a debug/loader port.
// The core has priority; an ageing counter forces a debug slot after
// MAX_WAIT lost cycles, freezing the pipeline for that one cycle.
// Optional build macro DMEM_ARB_STATS_EN adds stall and debug-ack counters.
module dmem_arbiter
  import Dmem_Arb_PKG::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           dbg_cnt
`endif
);

  arb_state_t state;
  arb_owner_t owner;
  logic       core_req;
  logic       dbg_elig;
  logic       dbg_grant;
  logic       age_at_max;
  logic       age_inc;
  logic       age_clear;

  // A request presented during its own ACK cycle is ignored; it becomes a new
  // transaction from the following cycle.
  assign core_req   = core_rd | core_wr;
  assign dbg_elig   = dbg_req & (state != ARB_ACK);
  assign dbg_grant  = dbg_elig & (~core_req | age_at_max);
  assign core_stall = dbg_elig & core_req & age_at_max;

  // Age only while a debug request is losing; any other outcome restarts it.
  assign age_inc    = dbg_elig & ~dbg_grant;
  assign age_clear  = ~age_inc;

  dmem_arb_age_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (age_clear),
    .inc    (age_inc),
    .at_max (age_at_max)
  );

  // Select this cycle's single owner of the memory port.
  always_comb begin
    if (dbg_grant) begin
      owner = OWN_DBG;
    end else if (core_req) begin
      owner = OWN_CORE;
    end else begin
      owner = OWN_NONE;
    end
  end

  // Route the owner's fields to the memory; idle port keeps core fields with no strobes.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_funct3 = core_funct3;
    core_rdata = '0;
    case (owner)
      OWN_CORE: begin
        mem_rd     = core_rd;
        mem_wr     = core_wr;
        core_rdata = mem_rdata;
      end
      OWN_DBG: begin
        mem_rd     = ~dbg_we;
        mem_wr     = dbg_we;
        mem_addr   = dbg_addr;
        mem_wdata  = dbg_wdata;
        mem_funct3 = DBG_FUNCT3;
      end
      default: begin
      end
    endcase
  end

  // Debug transaction FSM with registered ack pulse and captured read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        ARB_IDLE, ARB_WAIT: begin
          if (dbg_grant) begin
            state   <= ARB_ACK;
            dbg_ack <= 1'b1;
            if (!dbg_we) begin
              dbg_rdata <= mem_rdata;
            end
          end else if (dbg_req) begin
            state <= ARB_WAIT;
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_ACK: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      dbg_cnt   <= '0;
    end else begin
      if (core_stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (dbg_ack) begin
        dbg_cnt <= dbg_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
